// File: rtl/ram_burst_pkg.sv
// rtl/ram_burst_pkg.sv - shared types and constants for the RAM burst master
package ram_burst_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LEN_W    = 4;
  // read beats allowed to be buffered or outstanding at the RAM at once
  localparam int RD_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// rtl/ram_rd_skid_fifo.sv - two-entry read data buffer feeding the read stream
module ram_rd_skid_fifo
  import ram_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] entry1;

  // entry0 is always the head; a pop shifts entry1 forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= entry1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head   <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - burst command controller driving a registered-read sync RAM
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    issued;
  logic [LEN_W:0]    taken;
  logic              primed;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic              pop;
  logic              issue;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign wr_ready  = (state == WRITE);
  assign rd_valid  = (fifo_count != 2'd0);
  assign pop       = rd_valid & rd_ready;

  // ram_addr is pre-positioned one cycle ahead, so an issue edge is the edge
  // where the RAM samples the pointer and dout is ready for the next edge
  always_comb begin
    issue = (state == READ) && primed && (issued <= {1'b0, len_q}) &&
            (((int'(fifo_count) + int'(inflight)) < RD_BUF_DEPTH) || pop);
  end

  ram_rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_dout),
    .pop       (pop),
    .count     (fifo_count),
    .head      (rd_data)
  );

  // burst sequencing, RAM port registers and beat accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      len_q    <= '0;
      issued   <= '0;
      taken    <= '0;
      primed   <= 1'b0;
      inflight <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we   <= 1'b0;
      inflight <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr    <= cmd_addr;
            len_q  <= cmd_len;
            issued <= '0;
            taken  <= '0;
            primed <= 1'b0;
            state  <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            ram_we   <= 1'b1;
            ram_addr <= ptr;
            ram_din  <= wr_data;
            ptr      <= ptr + ADDR_W'(1);
            issued   <= issued + (LEN_W+1)'(1);
            if (issued == {1'b0, len_q}) state <= FIN;
          end
        end
        READ: begin
          if (!primed) begin
            ram_addr <= ptr;
            primed   <= 1'b1;
          end else if (issue) begin
            inflight <= 1'b1;
            ptr      <= ptr + ADDR_W'(1);
            ram_addr <= ptr + ADDR_W'(1);
            issued   <= issued + (LEN_W+1)'(1);
          end
          if (pop) begin
            taken <= taken + (LEN_W+1)'(1);
            if (taken == {1'b0, len_q}) state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
Initiator-side controller that drives the sync_ram port (we/addr/din in, dout out) on behalf of a client. It accepts one burst command at a time over a valid/ready handshake and executes it against the RAM:
- For a write burst, it takes data beats from a write stream.
- For a read burst, it returns RAM data beats on a backpressurable read stream.

It sits between client logic and the sync_ram instance and owns all RAM timing.

Parameters:
ADDR_W, 4, RAM address width; RAM depth is 2**ADDR_W
DATA_W, 8, RAM data width
LEN_W, 4, width of burst length field; cmd_len encodes beats-1 (1..2**LEN_W beats)

Ports:
clk  input  1  rising-edge clock, shared with sync_ram
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when both high
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  LEN_W  beats minus one
wr_valid  input  1  write beat offered
wr_ready  output  1  write beat accepted when both high
wr_data  input  DATA_W  write beat data
rd_valid  output  1  read beat available
rd_ready  input  1  client accepts read beat
rd_data  output  DATA_W  read beat data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at burst completion
ram_we  output  1  to sync_ram we
ram_addr  output  ADDR_W  to sync_ram addr
ram_din  output  DATA_W  to sync_ram din
ram_dout  input  DATA_W  from sync_ram dout

Behaviour:
- RAM contract:
  - Writes happen at the rising edge where we=1.
  - Reads are registered: addr sampled at edge E gives dout = mem[addr] after E.
- Reset (async, any state):
  - State goes to IDLE.
  - ram_we=0, ram_addr=0, ram_din=0.
  - busy=0, done=0, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0.
  - FIFO emptied, in-flight flag cleared, beat counter and address pointer cleared.
  - A burst in progress is abandoned; partial writes already committed stay in RAM.
- ram_we, ram_addr, and ram_din are registered outputs.
- State machine:
  - IDLE:
    - cmd_ready=1.
    - On handshake: latch addr and len, clear beat counter, go to WRITE or READ per cmd_write.
  - WRITE:
    - wr_ready=1 until the last beat is accepted.
    - Each wr handshake at edge E: after E, ram_we=1, ram_addr=pointer, ram_din=wr_data. Pointer and counter then increment.
    - Edges without a beat: ram_we=0.
    - After the last beat, go to FIN.
  - READ:
    - Issue a read (ram_we=0, ram_addr=pointer, set in-flight) when all of the following hold:
      - beats issued < len+1
      - fifo_count + inflight < 2, OR a rd handshake occurs this cycle
    - The in-flight beat is captured from ram_dout into the FIFO on the following edge.
    - After the last rd handshake, go to FIN.
  - FIN:
    - done=1 for exactly one cycle, ram_we=0.
    - Next state IDLE; cmd_ready is low in FIN.
- Address pointer increments modulo 2**ADDR_W: 0xF wraps to 0x0 for ADDR_W=4.
- Latency:
  - Write: beat accepted at edge E is committed to RAM at E+1.
  - Read: cmd handshake at E0 gives first rd_valid after E3.
- Throughput: one beat per cycle in both directions when wr_valid or rd_ready is held high.
- rd_valid/rd_data come from the FIFO head:
  - Stable while rd_valid=1 and rd_ready=0.
  - No read is ever dropped or duplicated.
  - At most 2 beats are buffered plus in flight.
- cmd_valid while busy is ignored. wr_valid outside WRITE is ignored (wr_ready=0). ram_dout is ignored when nothing is in flight.
- Simultaneous FIFO push and pop: count unchanged, ordering preserved.

Decomposition:
- Package ram_burst_pkg:
  - State enum: IDLE, WRITE, READ, FIN.
  - Default widths ADDR_W/DATA_W/LEN_W.
  - Constant RD_BUF_DEPTH=2.
- Sub-module ram_rd_skid_fifo: 2-entry DATA_W FIFO with push, pop, count, and head outputs; async active-low reset.

Test Plan:
1. Write cmd addr=1, len=2 with beats A5, 5A, 3C, wr_valid held high -> ram_we high for 3 consecutive cycles with addr 1, 2, 3 and data A5, 5A, 3C; done pulses once; then a read cmd addr=1, len=2 returns rd_data A5, 5A, 3C in order.
2. Wrap: write addr=F, len=1 with data 11, 22 -> RAM writes at F then 0; reading addr=F, len=1 returns 11, 22.
3. Read backpressure: 8-beat read with rd_ready low for 4 cycles after the 2nd beat -> rd_data held stable, at most 2 reads outstanding, all 8 beats returned correct and in order.
4. Full-rate read: write 16 distinct values, then read addr=0, len=F with rd_ready=1 -> 16 consecutive rd_valid cycles starting 3 edges after the cmd handshake.
5. Write gaps: wr_valid toggling 1/0 -> ram_we toggles accordingly, no extra writes, done only after the 4th beat.
6. Reset mid-burst: assert rst_n=0 during beat 3 of a read -> all outputs at reset values immediately; after release cmd_ready=1 and a new write cmd executes normally.
